// File: rtl/div_issue_ctrl.sv
// Issue/stall controller for the shared multicycle divider (DIV/DIVU in EX).
// Optional macro DIV_ZERO_FAST_EN: retire zero-divisor divides as 0/0 without starting the divider.
module div_issue_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid_i,
    input  logic        ex_div_signed_i,
    input  logic [31:0] ex_opa_i,
    input  logic [31:0] ex_opb_i,
    input  logic        ex_stall_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        DRAIN
    } StateT;

    StateT          r_state;
    StateT          w_nextState;
    logic [CW-1:0]  r_drainCnt;
    logic [CW-1:0]  w_drainNext;
    logic [31:0]    r_opa;
    logic [31:0]    r_opb;
    logic           r_signed;
    logic [31:0]    r_hi;
    logic [31:0]    r_lo;
    logic           w_capture;
    logic           w_latchResult;
    logic           w_clearResult;
    logic           w_zeroDiv;

`ifdef DIV_ZERO_FAST_EN
    assign w_zeroDiv = (ex_opb_i == 32'd0);
`else
    assign w_zeroDiv = 1'b0;
`endif

    always_comb begin
        w_nextState   = r_state;
        w_drainNext   = r_drainCnt;
        stall_o       = 1'b0;
        hilo_we_o     = 1'b0;
        div_start_o   = 1'b0;
        div_annul_o   = 1'b0;
        w_capture     = 1'b0;
        w_latchResult = 1'b0;
        w_clearResult = 1'b0;
        case (r_state)
            IDLE: begin
                if (ex_div_valid_i && !flush_i) begin
                    stall_o   = 1'b1;
                    w_capture = 1'b1;
                    if (w_zeroDiv) begin
                        w_clearResult = 1'b1;
                        w_nextState   = DONE;
                    end else begin
                        div_start_o = 1'b1;
                        w_nextState = BUSY;
                    end
                end
            end
            BUSY: begin
                // Flush wins over ready; dropping start on ready returns the divider to Free.
                if (flush_i) begin
                    div_annul_o = 1'b1;
                    w_drainNext = DRAIN_LOAD;
                    w_nextState = DRAIN;
                end else if (div_ready_i) begin
                    stall_o       = 1'b1;
                    w_latchResult = 1'b1;
                    w_nextState   = DONE;
                end else begin
                    stall_o     = 1'b1;
                    div_start_o = 1'b1;
                end
            end
            DONE: begin
                if (flush_i) begin
                    w_nextState = IDLE;
                end else if (!ex_stall_i) begin
                    hilo_we_o   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            DRAIN: begin
                stall_o = ex_div_valid_i;
                if (r_drainCnt == '0) begin
                    w_nextState = IDLE;
                end else begin
                    w_drainNext = r_drainCnt - 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_drainCnt <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_signed   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_state    <= w_nextState;
            r_drainCnt <= w_drainNext;
            if (w_capture) begin
                r_opa    <= ex_opa_i;
                r_opb    <= ex_opb_i;
                r_signed <= ex_div_signed_i;
            end
            if (w_latchResult) begin
                r_hi <= div_result_i[63:32];
                r_lo <= div_result_i[31:0];
            end else if (w_clearResult) begin
                r_hi <= '0;
                r_lo <= '0;
            end
        end
    end

    // The divider samples operands on the issue edge but reads sign bits again at finalisation.
    assign div_op1_o    = (r_state == IDLE) ? ex_opa_i        : r_opa;
    assign div_op2_o    = (r_state == IDLE) ? ex_opb_i        : r_opb;
    assign div_signed_o = (r_state == IDLE) ? ex_div_signed_i : r_signed;
    assign hi_o         = r_hi;
    assign lo_o         = r_lo;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural divider model answering start/annul.
// Honours DIV_ZERO_FAST_EN to pick the expected zero-divisor timing.
module tb_div_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_div_valid_i;
    logic        ex_div_signed_i;
    logic [31:0] ex_opa_i;
    logic [31:0] ex_opb_i;
    logic        ex_stall_i;
    logic        flush_i;
    logic        stall_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic [63:0] div_result_i = '0;
    logic        div_ready_i  = 1'b0;

    int checks = 0;
    int errors = 0;
    int writeCount = 0;
    int annulCount = 0;
    logic [63:0] expQ[$];

    localparam logic [1:0] M_FREE = 2'd0;
    localparam logic [1:0] M_BUSY = 2'd1;
    localparam logic [1:0] M_READY = 2'd2;
    logic [1:0]  mState = M_FREE;
    int          mCnt = 0;
    logic [31:0] mOpa = '0;
    logic [31:0] mOpb = '0;
    logic        mSigned = 1'b0;

    div_issue_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk(clk),
        .rst(rst),
        .ex_div_valid_i(ex_div_valid_i),
        .ex_div_signed_i(ex_div_signed_i),
        .ex_opa_i(ex_opa_i),
        .ex_opb_i(ex_opb_i),
        .ex_stall_i(ex_stall_i),
        .flush_i(flush_i),
        .stall_o(stall_o),
        .hilo_we_o(hilo_we_o),
        .hi_o(hi_o),
        .lo_o(lo_o),
        .div_start_o(div_start_o),
        .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o),
        .div_op2_o(div_op2_o),
        .div_result_i(div_result_i),
        .div_ready_i(div_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] computeResult(input logic [31:0] a, input logic [31:0] b,
                                                  input logic s);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else if (s) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Divider model: latches operands on the start edge, answers after a fixed latency,
    // holds ready while start stays high, and returns to Free when start drops or annul pulses.
    always @(posedge clk) begin
        if (rst || div_annul_o || !div_start_o) begin
            mState      <= M_FREE;
            div_ready_i <= 1'b0;
        end else if (mState == M_FREE) begin
            mOpa    <= div_op1_o;
            mOpb    <= div_op2_o;
            mSigned <= div_signed_o;
            mCnt    <= (div_op2_o == 32'd0) ? 1 : 33;
            mState  <= M_BUSY;
        end else if (mState == M_BUSY) begin
            if (mCnt > 1) begin
                mCnt <= mCnt - 1;
            end else begin
                mState       <= M_READY;
                div_ready_i  <= 1'b1;
                div_result_i <= computeResult(mOpa, mOpb, mSigned);
            end
        end
    end

    // Monitor: scoreboard pops on every write strobe; also watches operand stability and start/ready overlap.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (div_annul_o === 1'b1) annulCount++;
        if (hilo_we_o === 1'b1) begin
            writeCount++;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected write: got HI=0x%08h LO=0x%08h, required no write", hi_o, lo_o);
            end else begin
                exp = expQ.pop_front();
                if ({hi_o, lo_o} !== exp) begin
                    errors++;
                    $display("[TB] FAIL hilo value: got HI=0x%08h LO=0x%08h, required HI=0x%08h LO=0x%08h",
                             hi_o, lo_o, exp[63:32], exp[31:0]);
                end
            end
        end
        if (mState != M_FREE) begin
            checks++;
            if ({div_signed_o, div_op1_o, div_op2_o} !== {mSigned, mOpa, mOpb}) begin
                errors++;
                $display("[TB] FAIL operand hold: got s=%0b op1=0x%08h op2=0x%08h, required s=%0b op1=0x%08h op2=0x%08h",
                         div_signed_o, div_op1_o, div_op2_o, mSigned, mOpa, mOpb);
            end
        end
        if (div_ready_i === 1'b1) begin
            checks++;
            if (div_start_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL start during ready: got %0b, required 0", div_start_o);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b);
        @(posedge clk);
        #1;
        ex_div_valid_i  = valid;
        ex_div_signed_i = sgn;
        ex_opa_i        = a;
        ex_opb_i        = b;
    endtask

    // Counts cycles from the current one until the write strobe; cycle 0 is the current cycle.
    task automatic waitWrite(input int maxCycles, output int n, output int startHigh, output int stallLow);
        int i;
        startHigh = 0;
        stallLow  = 0;
        for (i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (hilo_we_o === 1'b1) break;
            if (div_start_o === 1'b1) startHigh++;
            if (stall_o !== 1'b1) stallLow++;
        end
        n = i;
        if (i == maxCycles) begin
            checks++;
            errors++;
            $display("[TB] FAIL write timeout: got no write in %0d cycles, required one", maxCycles);
        end
    endtask

    task automatic waitReady(input int maxCycles);
        int i;
        for (i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (div_ready_i === 1'b1) break;
        end
        if (i == maxCycles) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready timeout: got no ready in %0d cycles, required one", maxCycles);
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int sh;
        int sl;
        int annulBefore;
        rst = 1'b1;
        ex_div_valid_i = 1'b0;
        ex_div_signed_i = 1'b0;
        ex_opa_i = '0;
        ex_opb_i = '0;
        ex_stall_i = 1'b0;
        flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("reset stall", stall_o, 0);
        checkOutput("reset write", hilo_we_o, 0);
        checkOutput("reset start", div_start_o, 0);
        checkOutput("reset annul", div_annul_o, 0);
        checkOutput("reset hi", hi_o, 0);
        checkOutput("reset lo", lo_o, 0);
        checkOutput("reset op", {div_signed_o, div_op1_o, div_op2_o}, 0);

        $display("[TB] DIVU 100/7");
        expQ.push_back({32'h00000002, 32'h0000000E});
        applyStimulus(1'b1, 1'b0, 32'd100, 32'd7);
        waitWrite(200, n, sh, sl);
        checkOutput("t1 write cycle", n, 35);
        checkOutput("t1 start cycles", sh, 34);
        checkOutput("t1 stall low", sl, 0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("t1 idle stall", stall_o, 0);
        checkOutput("t1 idle start", div_start_o, 0);

        $display("[TB] DIV -7/2 with EX operands changing under the stall");
        expQ.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        applyStimulus(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
        applyStimulus(1'b1, 1'b0, 32'h12345678, 32'd0);
        waitWrite(200, n, sh, sl);
        checkOutput("t2 stall low", sl, 0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        $display("[TB] DIV 50/5 flushed in BUSY, then DIVU 9/4");
        applyStimulus(1'b1, 1'b1, 32'd50, 32'd5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        flush_i = 1'b1;
        annulBefore = annulCount;
        @(negedge clk);
        checkOutput("t3 annul", div_annul_o, 1);
        checkOutput("t3 flush start", div_start_o, 0);
        checkOutput("t3 flush stall", stall_o, 0);
        expQ.push_back({32'h00000001, 32'h00000002});
        applyStimulus(1'b1, 1'b0, 32'd9, 32'd4);
        flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("t3 drain start", div_start_o, 0);
            checkOutput("t3 drain stall", stall_o, 1);
            checkOutput("t3 drain annul", div_annul_o, 0);
        end
        waitWrite(200, n, sh, sl);
        checkOutput("t3 write cycle", n, 35);
        checkOutput("t3 start cycles", sh, 34);
        checkOutput("t3 annul pulses", annulCount - annulBefore, 1);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        $display("[TB] DIVU 10/3 held by downstream stall");
        expQ.push_back({32'h00000001, 32'h00000003});
        applyStimulus(1'b1, 1'b0, 32'd10, 32'd3);
        ex_stall_i = 1'b1;
        waitReady(200);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t4 held write", hilo_we_o, 0);
            checkOutput("t4 held start", div_start_o, 0);
        end
        @(posedge clk);
        #1 ex_stall_i = 1'b0;
        waitWrite(10, n, sh, sl);
        checkOutput("t4 write cycle", n, 0);
        checkOutput("t4 reissue", sh, 0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        $display("[TB] back-to-back DIVU 8/2, 9/3");
        expQ.push_back({32'h00000000, 32'h00000004});
        applyStimulus(1'b1, 1'b0, 32'd8, 32'd2);
        waitWrite(200, n, sh, sl);
        checkOutput("t5a write cycle", n, 35);
        expQ.push_back({32'h00000000, 32'h00000003});
        applyStimulus(1'b1, 1'b0, 32'd9, 32'd3);
        waitWrite(200, n, sh, sl);
        checkOutput("t5b write cycle", n, 35);
        checkOutput("t5b start cycles", sh, 34);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        $display("[TB] DIVU 5/0");
        expQ.push_back({32'h00000000, 32'h00000000});
        applyStimulus(1'b1, 1'b0, 32'd5, 32'd0);
        waitWrite(200, n, sh, sl);
`ifdef DIV_ZERO_FAST_EN
        checkOutput("t6 write cycle", n, 1);
        checkOutput("t6 start cycles", sh, 0);
`else
        checkOutput("t6 write cycle", n, 3);
        checkOutput("t6 start cycles", sh, 2);
`endif
        checkOutput("t6 stall low", sl, 0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        repeat (5) @(negedge clk);
        checkOutput("total writes", writeCount, 7);
        checkOutput("total annuls", annulCount, 1);
        checkOutput("scoreboard empty", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
